pending_encoder: RTL
====================

Name: pending_encoder

Overview:
- Sequential 8-to-3 encoder: the inverse of the team's 3-to-8 enable decoder.
- Captures requests on 8 one-hot/multi-hot lines into a pending register.
- Emits the index of one pending request at a time as a 3-bit code, using a valid/ready handshake.
- Clears each request once it is accepted. Sits between request sources (interrupts, event flags) and any consumer of a binary index, including the existing decoder.

Parameters:
- N, 8, number of request lines (fixed at 8 for this revision).
- IDX_W, 3, width of encoded index (log2 N).

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      synchronous, active-high reset
- en     input   1      capture enable; when 0, new requests on in are ignored
- in     input   8      request lines, sampled every cycle while en=1
- ready  input   1      consumer accepts out this cycle when valid=1
- out    output  3      encoded index of the granted request (registered)
- valid  output  1      out holds a valid index (registered)
- pend   output  8      current pending vector (registered)
- ovf    output  1      sticky: a request hit an already-pending, not-cleared bit

Behaviour:
- Reset: on a clk edge with rst=1, pend=0, out=0, valid=0, ovf=0, FSM=IDLE. rst overrides all other inputs, including mid-handshake; the pending request is lost.
- Capture: set = en ? in : 8'h00. Next pend = (pend & ~clr) | set. clr is one-hot of out when valid&ready, else 0.
- Set/clear collision: if set[i] and clr[i] occur in the same cycle, set wins. The bit stays pending and ovf is not raised.
- Overflow: ovf <= 1 if any i has set[i] & pend[i] & ~clr[i]. ovf stays set until rst.
- Selection: nxt = index of the lowest set bit of cand, where cand = next pend computed above. Bit 0 has the highest priority; bit 0 maps to code 0, matching the decoder.
- FSM IDLE:
  - valid=0; out holds its last value.
  - If pend != 0: load out = lowest set index of pend, set valid=1, go to HOLD.
  - Requests captured in a given cycle can therefore be presented no earlier than one cycle after they appear in pend. Latency from in to valid is 2 clk edges.
- FSM HOLD:
  - valid=1. out is stable while ready=0.
  - On ready=1: clear pend[out]. If cand != 0, load out = nxt and stay in HOLD (back-to-back, one grant per cycle). Otherwise valid<=0 and go to IDLE.
- en=0 blocks only capture. Draining of already-pending requests continues normally.
- ready while valid=0 is ignored.
- All outputs are registered; there is no combinational path from in or ready to any output.

Optional Feature:
- Macro: PENDING_ENCODER_ROUND_ROBIN_EN.
- Defined: rotating priority. An internal 3-bit pointer last resets to 7. Selection searches upward from last+1, wrapping 7→0. last <= out on every accepted handshake.
  - Example: pend=8'b1000_0011 with last=0 grants 1, then 7, then 0.
- Undefined: fixed lowest-index priority as above; no pointer logic is present.

Test Plan:
- Reset/idle: rst=1 for 2 cycles with in=8'hFF and en=1 → pend=0, valid=0, out=0, ovf=0. After release with in=0, valid stays 0.
- Single request: in=8'b0010_0000 for 1 cycle, en=1, ready=1 → pend[5]=1 after edge 1; valid=1 with out=5 after edge 2; pend=0 and valid=0 after edge 3.
- Priority drain, ready held 1: in=8'b1001_0100 pulsed once → out sequence 2, 4, 7 on consecutive cycles, then valid=0. With the macro defined, from reset the order is 2, 4, 7; with a preset last=3 it is 4, 7, 2.
- Backpressure: pend={3,6}, ready=0 for 5 cycles → out=3 stable, valid=1. ready=1 → out=6 next cycle.
- Collision/overflow: while out=3 is being accepted, pulse in[3]=1 → pend[3] stays 1, ovf=0, and 3 is re-granted. Pulse in[6] while pend[6]=1 and not accepted → ovf=1, held until rst.
- Enable gating: en=0 with in=8'hFF → pend unchanged and existing pending requests still drain. Reset asserted mid-HOLD → all outputs 0 on the next edge.

Source files
------------

// File: rtl/pending_encoder_if.sv
// Request/grant bus for the pending encoder.
// The slave modport is the encoder. The master modport is the side that
// raises requests and consumes the granted index.
interface pending_encoder_if #(
    parameter int N     = 8,
    parameter int IDX_W = 3
);
    logic             en;
    logic [N-1:0]     in;
    logic             ready;
    logic [IDX_W-1:0] out;
    logic             valid;
    logic [N-1:0]     pend;
    logic             ovf;

    modport slave (
        input  en, in, ready,
        output out, valid, pend, ovf
    );

    modport master (
        output en, in, ready,
        input  out, valid, pend, ovf
    );
endinterface

// File: rtl/pending_encoder.sv
// pending_encoder: sequential 8-to-3 encoder with a pending register.
// Requests are latched into pend. One pending index is presented at a time
// on out/valid. A request is cleared when the consumer accepts it.
// Optional macro PENDING_ENCODER_ROUND_ROBIN_EN selects rotating priority.
// When the macro is left undefined, bit 0 always has the highest priority.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | nothing presented; the next cycle grants if pend is non-zero
// HOLD  | out/valid presented; out is held until ready, then next grant
module pending_encoder #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic clk,
    input  logic rst,
    pending_encoder_if.slave bus
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state;
    logic [N-1:0]     pend_q;
    logic [IDX_W-1:0] out_q;
    logic             valid_q;
    logic             ovf_q;

    logic [N-1:0]     set;
    logic [N-1:0]     clr;
    logic [N-1:0]     cand;
    logic             accept;
    logic             ovf_hit;
    logic [IDX_W-1:0] sel_pend;
    logic [IDX_W-1:0] sel_cand;

    // Returns the index of the lowest set bit, or 0 when v is empty.
    function automatic logic [IDX_W-1:0] lowest(input logic [N-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) idx = i[IDX_W-1:0];
        end
        return idx;
    endfunction

`ifdef PENDING_ENCODER_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last;

    // Searches upward from base+1 and wraps past N-1.
    // The 3-bit sum wraps modulo 8 by truncation.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0] v,
                                                 input logic [IDX_W-1:0] base);
        logic [IDX_W-1:0] start;
        logic [2*N-1:0]   dbl;
        logic [N-1:0]     rot;
        start = base + 1'b1;
        dbl   = {v, v} >> start;
        rot   = dbl[N-1:0];
        return lowest(rot) + start;
    endfunction
`endif

    // Capture, clear and collision terms, and selection for the next grant.
    always_comb begin
        accept  = valid_q & bus.ready;
        set     = bus.en ? bus.in : '0;
        clr     = accept ? ({{(N-1){1'b0}}, 1'b1} << out_q) : '0;
        cand    = (pend_q & ~clr) | set;
        ovf_hit = |(set & pend_q & ~clr);
`ifdef PENDING_ENCODER_ROUND_ROBIN_EN
        sel_pend = rr_pick(pend_q, last);
        sel_cand = rr_pick(cand, out_q);
`else
        sel_pend = lowest(pend_q);
        sel_cand = lowest(cand);
`endif
    end

    // Grant FSM with the pending register and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pend_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef PENDING_ENCODER_ROUND_ROBIN_EN
            last    <= IDX_W'(N - 1);
`endif
        end else begin
            pend_q <= cand;
            if (ovf_hit) ovf_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (|pend_q) begin
                        out_q   <= sel_pend;
                        valid_q <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.ready) begin
`ifdef PENDING_ENCODER_ROUND_ROBIN_EN
                        last <= out_q;
`endif
                        if (|cand) begin
                            out_q <= sel_cand;
                        end else begin
                            valid_q <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.pend  = pend_q;
    assign bus.out   = out_q;
    assign bus.valid = valid_q;
    assign bus.ovf   = ovf_q;

endmodule
